signal_to_note: RTL and testbench

//  Pitch decoder: measures period of incoming speaker square wave, reports the 5-bit note

---
 rtl/note_pkg.sv | 37 +++
 rtl/signal_to_note_if.sv | 30 +++
 rtl/signal_to_note_edge_sync.sv | 31 +++
 rtl/signal_to_note.sv | 143 ++++++++++++++
 tb/tb_signal_to_note.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Note table shared by the pitch decoder and the tone generator.
// Entries are in ascending pitch order; the decoder scans them in this order.
package note_pkg;

  localparam int DIV_NUM_DEFAULT = 5000;
  localparam int NUM_NOTES       = 21;

  typedef logic [4:0] note_code_t;

  localparam note_code_t NOTE_REST = 5'd0;

  // C4..B4 use codes 25..31, C5..B6 use codes 1..14
  localparam note_code_t NOTE_CODE [NUM_NOTES] = '{
    5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31,
    5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14
  };

  localparam int NOTE_FREQ [NUM_NOTES] = '{
    262,  294,  330,  349,  392,  440,  494,
    523,  587,  659,  699,  784,  880,  988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976
  };

  // FSM encoding kept as plain constants so older code can compare against them
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEASURE = 3'd1;
  localparam logic [2:0] ST_SCAN    = 3'd2;
  localparam logic [2:0] ST_REPORT  = 3'd3;
  localparam logic [2:0] ST_SILENT  = 3'd4;

  // Tone half-period in clk cycles for a given frequency
  function automatic int half_period(input int freq, input int div = DIV_NUM_DEFAULT);
    return div / freq;
  endfunction

endpackage

// File: rtl/signal_to_note_if.sv
// Speaker-monitor bus: square wave in, decoded note and measurement out.
interface signal_to_note_if #(
  parameter int CNT_W = 16
);

  logic             sig_in;
  logic [4:0]       note;
  logic             note_valid;
  logic             active;
  logic [CNT_W-1:0] period;

  // Side that produces the square wave and consumes the decode
  modport master (
    output sig_in,
    input  note,
    input  note_valid,
    input  active,
    input  period
  );

  // The decoder itself
  modport slave (
    input  sig_in,
    output note,
    output note_valid,
    output active,
    output period
  );

endinterface

// File: rtl/signal_to_note_edge_sync.sv
// Brings the asynchronous speaker signal into the clk domain and produces a
// one-cycle pulse for each rising edge, three cycles after the input edge.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Two-flop synchronizer, delay stage and registered rising-edge detect
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous value of its neighbour; blocking here would collapse the chain.
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= sig_in;
      sync2      <= sync1;
      sync2_d    <= sync2;
      edge_pulse <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/signal_to_note.sv
// Pitch decoder: measures the period of the speaker square wave and reports
// the note whose tone half-period is nearest, or rest after a silence timeout.
//
// The interval counter restarts on every synchronized rising edge, including
// edges that arrive while the table scan is busy. That way the edge accepted in
// MEASURE always closes exactly one period, even when the previous edge was
// dropped because the scan was still running.
module signal_to_note
  import note_pkg::*;
#(
  parameter int DIV_NUM = DIV_NUM_DEFAULT,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  signal_to_note_if.slave   bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [4:0]       LAST_IDX  = 5'(NUM_NOTES - 1);

  logic             edge_pulse;
  logic [2:0]       state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] half;
  logic [4:0]       scan_idx;
  logic [CNT_W-1:0] best_diff;
  note_code_t       best_code;
  note_code_t       note_q;
  logic             note_valid_q;
  logic             active_q;
  logic [CNT_W-1:0] period_q;

  logic [CNT_W-1:0] half_tbl [NUM_NOTES];
  logic [CNT_W-1:0] tbl_val;
  logic [CNT_W-1:0] diff;

  edge_sync u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (bus.sig_in),
    .edge_pulse (edge_pulse)
  );

  // Constant half-period table, elaborated from the frequency list
  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_tbl
    assign half_tbl[gi] = CNT_W'(half_period(NOTE_FREQ[gi], DIV_NUM));
  end

  // Distance between the measured half-period and the entry under scan
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    tbl_val = half_tbl[scan_idx];
    diff    = '0;
    if (half >= tbl_val) diff = half - tbl_val;
    else                 diff = tbl_val - half;
  end

  // Interval counter: restarts on every edge, saturates at the silence timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= '0;
    end else if (edge_pulse) begin
      counter <= '0;
    end else if (counter != TIMEOUT_C) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Measurement / scan / report sequencer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      half         <= '0;
      scan_idx     <= '0;
      best_diff    <= '0;
      best_code    <= NOTE_REST;
      note_q       <= NOTE_REST;
      note_valid_q <= 1'b0;
      active_q     <= 1'b0;
      period_q     <= '0;
    end else begin
      note_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First edge only arms the measurement
          if (edge_pulse) state <= ST_MEASURE;
        end

        ST_MEASURE: begin
          if (edge_pulse) begin
            period_q  <= counter + CNT_W'(1);
            half      <= (counter + CNT_W'(2)) >> 1;
            scan_idx  <= '0;
            best_diff <= '1;
            best_code <= NOTE_REST;
            state     <= ST_SCAN;
          end else if (counter == TIMEOUT_C) begin
            state <= ST_SILENT;
          end
        end

        ST_SCAN: begin
          // Strict compare keeps the lower-pitch entry on a tie
          if (diff < best_diff) begin
            best_diff <= diff;
            best_code <= NOTE_CODE[scan_idx];
          end
          if (scan_idx == LAST_IDX) state <= ST_REPORT;
          else                      scan_idx <= scan_idx + 5'd1;
        end

        ST_REPORT: begin
          active_q <= 1'b1;
          if (best_code != note_q) begin
            note_q       <= best_code;
            note_valid_q <= 1'b1;
          end
          state <= ST_MEASURE;
        end

        ST_SILENT: begin
          active_q <= 1'b0;
          if (note_q != NOTE_REST) begin
            note_q       <= NOTE_REST;
            note_valid_q <= 1'b1;
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.active     = active_q;
  assign bus.period     = period_q;

endmodule

// File: tb/tb_signal_to_note.sv
// Randomized bench for the pitch decoder. Stimulus pushes the expected note
// change events into a scoreboard; a monitor pops one entry per note_valid.
module tb_signal_to_note;

  localparam int CNT_W   = 16;
  localparam int DIV     = 5000;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  signal_to_note_if #(.CNT_W(CNT_W)) bus ();

  signal_to_note #(
    .DIV_NUM (DIV),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int note;
    int active;
    int period;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   errors      = 0;
  int   last_note   = 0;
  int   last_period = 0;

  // Musical scale, lowest pitch first, with the code each pitch reports
  int ref_code [21] = '{25, 26, 27, 28, 29, 30, 31, 1, 2, 3, 4, 5, 6, 7,
                        8, 9, 10, 11, 12, 13, 14};
  int ref_freq [21] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 699,
                        784, 880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976};

  // Nearest pitch to a steady tone of period p; first (lowest) wins a tie
  function automatic int ref_note(int p);
    int h;
    int best;
    int best_d;
    h      = (p + 1) / 2;
    best   = 0;
    best_d = 1 << 30;
    for (int i = 0; i < 21; i++) begin
      int d;
      d = h - DIV / ref_freq[i];
      if (d < 0) d = -d;
      if (d < best_d) begin
        best_d = d;
        best   = ref_code[i];
      end
    end
    return best;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of a steady tone of period p
  task automatic expect_tone(int p);
    int n;
    n = ref_note(p);
    if (n != last_note) sb.push_back('{n, 1, p});
    last_note   = n;
    last_period = p;
  endtask

  // Square wave: rising edge every p cycles, high p/2, low the rest
  task automatic play(int p, int nper);
    for (int k = 0; k < nper; k++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        bus.sig_in = (c < p / 2);
      end
    end
  endtask

  task automatic tone(int p, int nper);
    expect_tone(p);
    play(p, nper);
  endtask

  task automatic silence(int cycles);
    if (last_note != 0) sb.push_back('{0, 0, last_period});
    last_note = 0;
    repeat (cycles) begin
      @(negedge clk);
      bus.sig_in = 1'b0;
    end
  endtask

  // One period of a p>=44 tone with reset pulled while the table scan runs
  task automatic reset_in_scan(int p);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      bus.sig_in = (c < p / 2);
      if (c == 13) reset = 1'b0;
      if (c == 14) begin
        check("scan_reset_note",   int'(bus.note),       0);
        check("scan_reset_valid",  int'(bus.note_valid), 0);
        check("scan_reset_active", int'(bus.active),     0);
        check("scan_reset_period", int'(bus.period),     0);
      end
      if (c == 30) reset = 1'b1;
    end
    last_note = 0;
    expect_tone(p);
  endtask

  // Monitor: every note_valid pulse must match the oldest expected event
  always @(negedge clk) begin
    exp_t e;
    if (bus.note_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: note=%0d period=%0d, expected no pulse (t=%0t)",
                 bus.note, bus.period, $time);
      end else begin
        e = sb.pop_front();
        check("note",   int'(bus.note),   e.note);
        check("active", int'(bus.active), e.active);
        check("period", int'(bus.period), e.period);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    bus.sig_in = 1'b0;
    reset      = 1'b0;

    // Reset held with the input toggling, input parked low before release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.sig_in = (i < 8) ? ((i % 2) == 1) : 1'b0;
    end
    check("reset_note",   int'(bus.note),       0);
    check("reset_valid",  int'(bus.note_valid), 0);
    check("reset_active", int'(bus.active),     0);
    check("reset_period", int'(bus.period),     0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Directed tones
    tone(18, 14);   // half 9  -> code 1
    tone(38, 14);   // half 19 -> code 25, then steady with no further pulse
    tone(14, 20);   // half 7  -> code 3 (tie with 699 Hz)
    tone(10, 25);   // half 5  -> code 6 (tie with 988 Hz)
    tone(19, 15);   // half 10 -> code 31
    tone(38, 10);   // back to code 25
    silence(150);   // timeout -> rest

    // Random steady tones
    repeat (10) begin
      p = int'($urandom_range(4, 60));
      tone(p, 300 / p + 4);
    end

    // Reset during SCAN, then re-lock on the same tone
    tone(50, 4);
    reset_in_scan(50);
    play(50, 5);
    silence(150);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
